// File: rtl/store_addr_if.sv
// Store address unit bus: LSU request, DTLB/MMU, store buffer, writeback.
// slave = unit side, master = environment side.
interface store_addr_if #(
  parameter int TRANS_ID_BITS = 3
);
  logic                     valid_i;
  logic                     ready_o;
  logic [63:0]              vaddr_i;
  logic [63:0]              data_i;
  logic [7:0]               be_i;
  logic [1:0]               data_size_i;
  logic [TRANS_ID_BITS-1:0] trans_id_i;

  logic                     translation_req_o;
  logic [63:0]              vaddr_o;
  logic [63:0]              paddr_i;
  logic                     dtlb_hit_i;
  logic                     mmu_exception_i;

  logic                     st_ready_i;
  logic                     st_valid_o;
  logic                     st_valid_without_flush_o;
  logic [63:0]              st_paddr_o;
  logic [63:0]              st_data_o;
  logic [7:0]               st_be_o;
  logic [1:0]               st_data_size_o;

  logic                     valid_o;
  logic [TRANS_ID_BITS-1:0] trans_id_o;
  logic                     ex_valid_o;
  logic [63:0]              ex_cause_o;
  logic [63:0]              ex_tval_o;

  modport slave (
    input  valid_i, vaddr_i, data_i, be_i,
    input  data_size_i, trans_id_i,
    output ready_o,
    output translation_req_o, vaddr_o,
    input  paddr_i, dtlb_hit_i, mmu_exception_i,
    input  st_ready_i,
    output st_valid_o, st_valid_without_flush_o,
    output st_paddr_o, st_data_o, st_be_o,
    output st_data_size_o,
    output valid_o, trans_id_o, ex_valid_o,
    output ex_cause_o, ex_tval_o
  );

  modport master (
    output valid_i, vaddr_i, data_i, be_i,
    output data_size_i, trans_id_i,
    input  ready_o,
    input  translation_req_o, vaddr_o,
    output paddr_i, dtlb_hit_i, mmu_exception_i,
    output st_ready_i,
    input  st_valid_o, st_valid_without_flush_o,
    input  st_paddr_o, st_data_o, st_be_o,
    input  st_data_size_o,
    input  valid_o, trans_id_o, ex_valid_o,
    input  ex_cause_o, ex_tval_o
  );
endinterface

// File: rtl/store_addr_unit.sv
// Store address unit: align check, DTLB translate, push to store buffer.
// Ports: clk_i, rst_ni (async low), flush_i, bus (store_addr_if.slave).
module store_addr_unit #(
  parameter int TRANS_ID_BITS = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  store_addr_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    TRANSLATE,
    WAIT_STORE
  } state_e;

  localparam logic [63:0] CAUSE_MISALIGN = 64'd6;
  localparam logic [63:0] CAUSE_PFAULT   = 64'd15;

  state_e state_q, state_d;

  logic [63:0]              vaddr_q;
  logic [63:0]              data_q;
  logic [7:0]               be_q;
  logic [1:0]               size_q;
  logic [TRANS_ID_BITS-1:0] id_q;
  logic [63:0]              paddr_q;

  logic                     cmp_valid_q, cmp_valid_d;
  logic                     cmp_ex_q, cmp_ex_d;
  logic [TRANS_ID_BITS-1:0] cmp_id_q, cmp_id_d;
  logic [63:0]              cause_q, cause_d;
  logic [63:0]              tval_q, tval_d;

  logic accept;
  logic latch_paddr;
  logic misaligned;
  logic st_push;

  always_comb begin
    misaligned = 1'b0;
    unique case (bus.data_size_i)
      2'd3:    misaligned = |bus.vaddr_i[2:0];
      2'd2:    misaligned = |bus.vaddr_i[1:0];
      2'd1:    misaligned = bus.vaddr_i[0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    latch_paddr = 1'b0;
    st_push     = 1'b0;
    cmp_valid_d = 1'b0;
    cmp_ex_d    = 1'b0;
    cmp_id_d    = '0;
    cause_d     = '0;
    tval_d      = '0;

    bus.ready_o                  = 1'b0;
    bus.translation_req_o        = 1'b0;
    bus.vaddr_o                  = '0;
    bus.st_valid_without_flush_o = 1'b0;
    bus.st_paddr_o               = '0;

    unique case (state_q)
      IDLE: begin
        bus.ready_o = 1'b1;
        if (bus.valid_i && !flush_i) begin
          accept = 1'b1;
          if (misaligned) begin
            cmp_valid_d = 1'b1;
            cmp_ex_d    = 1'b1;
            cmp_id_d    = bus.trans_id_i;
            cause_d     = CAUSE_MISALIGN;
            tval_d      = bus.vaddr_i;
          end else begin
            state_d = TRANSLATE;
          end
        end
      end
      TRANSLATE: begin
        bus.translation_req_o = 1'b1;
        bus.vaddr_o           = vaddr_q;
        if (bus.dtlb_hit_i) begin
          if (bus.mmu_exception_i) begin
            cmp_valid_d = 1'b1;
            cmp_ex_d    = 1'b1;
            cmp_id_d    = id_q;
            cause_d     = CAUSE_PFAULT;
            tval_d      = vaddr_q;
            state_d     = IDLE;
          end else begin
            bus.st_valid_without_flush_o = 1'b1;
            bus.st_paddr_o               = bus.paddr_i;
            latch_paddr                  = 1'b1;
            if (bus.st_ready_i) begin
              st_push     = 1'b1;
              cmp_valid_d = 1'b1;
              cmp_id_d    = id_q;
              state_d     = IDLE;
            end else begin
              state_d = WAIT_STORE;
            end
          end
        end
      end
      WAIT_STORE: begin
        bus.st_valid_without_flush_o = 1'b1;
        bus.st_paddr_o               = paddr_q;
        if (bus.st_ready_i) begin
          st_push     = 1'b1;
          cmp_valid_d = 1'b1;
          cmp_id_d    = id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush kills this cycle's push and completion; the
    // page-offset hint deliberately stays visible.
    if (flush_i) begin
      state_d     = IDLE;
      st_push     = 1'b0;
      cmp_valid_d = 1'b0;
      cmp_ex_d    = 1'b0;
      cmp_id_d    = '0;
      cause_d     = '0;
      tval_d      = '0;
    end
  end

  assign bus.st_valid_o     = st_push;
  assign bus.st_data_o      = data_q;
  assign bus.st_be_o        = be_q;
  assign bus.st_data_size_o = size_q;

  assign bus.valid_o    = cmp_valid_q;
  assign bus.ex_valid_o = cmp_ex_q;
  assign bus.trans_id_o = cmp_id_q;
  assign bus.ex_cause_o = cause_q;
  assign bus.ex_tval_o  = tval_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      vaddr_q     <= '0;
      data_q      <= '0;
      be_q        <= '0;
      size_q      <= '0;
      id_q        <= '0;
      paddr_q     <= '0;
      cmp_valid_q <= 1'b0;
      cmp_ex_q    <= 1'b0;
      cmp_id_q    <= '0;
      cause_q     <= '0;
      tval_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_ex_q    <= cmp_ex_d;
      cmp_id_q    <= cmp_id_d;
      cause_q     <= cause_d;
      tval_q      <= tval_d;
      if (accept) begin
        vaddr_q <= bus.vaddr_i;
        data_q  <= bus.data_i;
        be_q    <= bus.be_i;
        size_q  <= bus.data_size_i;
        id_q    <= bus.trans_id_i;
      end
      if (latch_paddr) begin
        paddr_q <= bus.paddr_i;
      end
    end
  end

endmodule

// File: tb/tb_store_addr_unit.sv
// Directed bench for store_addr_unit.
// Drives #1 after posedge, checks before the next edge.
module tb_store_addr_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_cmp = 0;
  int   n_bad = 0;

  store_addr_if #(.TRANS_ID_BITS(3)) bus ();

  store_addr_unit #(.TRANS_ID_BITS(3)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [63:0] va,
                     input logic [1:0] sz,
                     input logic [2:0] id);
    bus.valid_i     = 1'b1;
    bus.vaddr_i     = va;
    bus.data_size_i = sz;
    bus.trans_id_i  = id;
    bus.data_i      = {va[31:0], 32'hA5A5_0000};
    bus.be_i        = 8'hFF;
  endtask

  initial begin
    rst_n                = 1'b0;
    flush                = 1'b0;
    bus.valid_i          = 1'b0;
    bus.vaddr_i          = '0;
    bus.data_i           = '0;
    bus.be_i             = '0;
    bus.data_size_i      = '0;
    bus.trans_id_i       = '0;
    bus.paddr_i          = '0;
    bus.dtlb_hit_i       = 1'b0;
    bus.mmu_exception_i  = 1'b0;
    bus.st_ready_i       = 1'b0;
    tick();
    tick();
    chk("rst_ready", 64'(bus.ready_o), 64'd1);
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_ex", 64'(bus.ex_valid_o), 64'd0);
    chk("rst_id", 64'(bus.trans_id_o), 64'd0);
    chk("rst_cause", bus.ex_cause_o, 64'd0);
    chk("rst_tval", bus.ex_tval_o, 64'd0);
    chk("rst_treq", 64'(bus.translation_req_o), 64'd0);
    chk("rst_stv", 64'(bus.st_valid_o), 64'd0);
    chk("rst_data", bus.st_data_o, 64'd0);
    rst_n = 1'b1;
    tick();

    // aligned double, hit + ready
    req(64'h1000, 2'd3, 3'd2);
    #1;
    chk("t1_treq0", 64'(bus.translation_req_o), 64'd0);
    tick();
    bus.valid_i    = 1'b0;
    bus.dtlb_hit_i = 1'b1;
    bus.paddr_i    = 64'h8_0000_1000;
    bus.st_ready_i = 1'b1;
    #1;
    chk("t1_ready", 64'(bus.ready_o), 64'd0);
    chk("t1_treq", 64'(bus.translation_req_o), 64'd1);
    chk("t1_vaddr", bus.vaddr_o, 64'h1000);
    chk("t1_stv", 64'(bus.st_valid_o), 64'd1);
    chk("t1_paddr", bus.st_paddr_o, 64'h8_0000_1000);
    chk("t1_data", bus.st_data_o, 64'h0000_1000_A5A5_0000);
    chk("t1_be", 64'(bus.st_be_o), 64'hFF);
    chk("t1_size", 64'(bus.st_data_size_o), 64'd3);
    chk("t1_v_early", 64'(bus.valid_o), 64'd0);
    tick();
    bus.dtlb_hit_i = 1'b0;
    chk("t1_valid", 64'(bus.valid_o), 64'd1);
    chk("t1_id", 64'(bus.trans_id_o), 64'd2);
    chk("t1_ex", 64'(bus.ex_valid_o), 64'd0);
    chk("t1_cause", bus.ex_cause_o, 64'd0);
    chk("t1_rdy", 64'(bus.ready_o), 64'd1);
    tick();
    chk("t1_pulse", 64'(bus.valid_o), 64'd0);

    // misaligned word
    req(64'h1002, 2'd2, 3'd5);
    tick();
    bus.valid_i = 1'b0;
    chk("t2_valid", 64'(bus.valid_o), 64'd1);
    chk("t2_ex", 64'(bus.ex_valid_o), 64'd1);
    chk("t2_cause", bus.ex_cause_o, 64'd6);
    chk("t2_tval", bus.ex_tval_o, 64'h1002);
    chk("t2_id", 64'(bus.trans_id_o), 64'd5);
    chk("t2_treq", 64'(bus.translation_req_o), 64'd0);
    chk("t2_rdy", 64'(bus.ready_o), 64'd1);
    tick();
    chk("t2_pulse", 64'(bus.valid_o), 64'd0);

    // misaligned half, then misaligned double
    req(64'h2001, 2'd1, 3'd1);
    tick();
    chk("t2h_cause", bus.ex_cause_o, 64'd6);
    req(64'h2004, 2'd3, 3'd7);
    tick();
    bus.valid_i = 1'b0;
    chk("t2d_valid", 64'(bus.valid_o), 64'd1);
    chk("t2d_tval", bus.ex_tval_o, 64'h2004);
    chk("t2d_id", 64'(bus.trans_id_o), 64'd7);
    tick();

    // delayed TLB hit
    req(64'h3004, 2'd2, 3'd3);
    tick();
    bus.valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_treq", 64'(bus.translation_req_o), 64'd1);
      chk("t3_stv", 64'(bus.st_valid_o), 64'd0);
      tick();
    end
    bus.dtlb_hit_i = 1'b1;
    bus.paddr_i    = 64'h7_0000_3004;
    bus.st_ready_i = 1'b1;
    #1;
    chk("t3_push", 64'(bus.st_valid_o), 64'd1);
    chk("t3_paddr", bus.st_paddr_o, 64'h7_0000_3004);
    tick();
    bus.dtlb_hit_i = 1'b0;
    chk("t3_valid", 64'(bus.valid_o), 64'd1);
    chk("t3_id", 64'(bus.trans_id_o), 64'd3);
    tick();

    // page fault
    req(64'h8000_0000, 2'd3, 3'd1);
    tick();
    bus.valid_i         = 1'b0;
    bus.dtlb_hit_i      = 1'b1;
    bus.mmu_exception_i = 1'b1;
    #1;
    chk("t4_stv", 64'(bus.st_valid_o), 64'd0);
    chk("t4_vwf", 64'(bus.st_valid_without_flush_o), 64'd0);
    tick();
    bus.dtlb_hit_i      = 1'b0;
    bus.mmu_exception_i = 1'b0;
    chk("t4_valid", 64'(bus.valid_o), 64'd1);
    chk("t4_ex", 64'(bus.ex_valid_o), 64'd1);
    chk("t4_cause", bus.ex_cause_o, 64'd15);
    chk("t4_tval", bus.ex_tval_o, 64'h8000_0000);
    chk("t4_id", 64'(bus.trans_id_o), 64'd1);
    chk("t4_stv2", 64'(bus.st_valid_o), 64'd0);
    tick();

    // store buffer back-pressure
    req(64'h3008, 2'd3, 3'd4);
    tick();
    bus.valid_i    = 1'b0;
    bus.dtlb_hit_i = 1'b1;
    bus.paddr_i    = 64'h9000_3008;
    bus.st_ready_i = 1'b0;
    #1;
    chk("t5_vwf0", 64'(bus.st_valid_without_flush_o), 64'd1);
    chk("t5_stv0", 64'(bus.st_valid_o), 64'd0);
    tick();
    bus.dtlb_hit_i = 1'b0;
    bus.paddr_i    = 64'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_vwf", 64'(bus.st_valid_without_flush_o), 64'd1);
      chk("t5_paddr", bus.st_paddr_o, 64'h9000_3008);
      chk("t5_stv", 64'(bus.st_valid_o), 64'd0);
      chk("t5_treq", 64'(bus.translation_req_o), 64'd0);
      chk("t5_valid", 64'(bus.valid_o), 64'd0);
      tick();
    end
    bus.st_ready_i = 1'b1;
    #1;
    chk("t5_push", 64'(bus.st_valid_o), 64'd1);
    chk("t5_ppush", bus.st_paddr_o, 64'h9000_3008);
    tick();
    bus.st_ready_i = 1'b0;
    chk("t5_cvalid", 64'(bus.valid_o), 64'd1);
    chk("t5_id", 64'(bus.trans_id_o), 64'd4);
    chk("t5_ex", 64'(bus.ex_valid_o), 64'd0);
    tick();

    // flush in WAIT_STORE
    req(64'h4000, 2'd1, 3'd6);
    tick();
    bus.valid_i    = 1'b0;
    bus.dtlb_hit_i = 1'b1;
    bus.paddr_i    = 64'hA000_4000;
    tick();
    bus.dtlb_hit_i = 1'b0;
    tick();
    flush          = 1'b1;
    bus.st_ready_i = 1'b1;
    #1;
    chk("t6_stv", 64'(bus.st_valid_o), 64'd0);
    chk("t6_vwf", 64'(bus.st_valid_without_flush_o), 64'd1);
    tick();
    flush          = 1'b0;
    bus.st_ready_i = 1'b0;
    chk("t6_valid", 64'(bus.valid_o), 64'd0);
    chk("t6_rdy", 64'(bus.ready_o), 64'd1);
    tick();
    chk("t6_valid2", 64'(bus.valid_o), 64'd0);

    // valid_i during flush is dropped
    req(64'h5003, 2'd2, 3'd2);
    flush = 1'b1;
    tick();
    flush       = 1'b0;
    bus.valid_i = 1'b0;
    chk("t7_valid", 64'(bus.valid_o), 64'd0);
    chk("t7_rdy", 64'(bus.ready_o), 64'd1);

    // odd byte store is aligned; reset mid-translate
    req(64'h6001, 2'd0, 3'd5);
    tick();
    bus.valid_i = 1'b0;
    chk("t8_valid", 64'(bus.valid_o), 64'd0);
    chk("t8_treq", 64'(bus.translation_req_o), 64'd1);
    chk("t8_vaddr", bus.vaddr_o, 64'h6001);
    rst_n = 1'b0;
    #1;
    chk("t8_rst_treq", 64'(bus.translation_req_o), 64'd0);
    chk("t8_rst_rdy", 64'(bus.ready_o), 64'd1);
    chk("t8_rst_data", bus.st_data_o, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_addr_unit.md
Name: store_addr_unit

Overview:
- Upstream feeder of the store buffer.
- Accepts one store request from the LSU issue path and checks alignment.
- Obtains the physical address from the DTLB/MMU, then pushes the translated store into the speculative store buffer, honouring its ready signal.
- Returns a registered completion, or an exception, to the scoreboard writeback.

Parameters:
TRANS_ID_BITS, 3, width of scoreboard transaction id

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
flush_i  in  1  kill in-flight request
valid_i  in  1  new store request
ready_o  out  1  unit can accept request (state IDLE)
vaddr_i  in  64  store virtual address
data_i  in  64  store data, already byte-lane aligned
be_i  in  8  byte enables
data_size_i  in  2  0=byte 1=half 2=word 3=double
trans_id_i  in  TRANS_ID_BITS  scoreboard id
translation_req_o  out  1  request MMU translation
vaddr_o  out  64  address to translate
paddr_i  in  64  translated address, valid when dtlb_hit_i
dtlb_hit_i  in  1  translation valid this cycle
mmu_exception_i  in  1  page fault, qualified by dtlb_hit_i
st_ready_i  in  1  store buffer can take entry
st_valid_o  out  1  push entry into store buffer
st_valid_without_flush_o  out  1  address valid for page-offset check, ignores flush
st_paddr_o  out  64  physical address to store buffer
st_data_o  out  64  data
st_be_o  out  8  byte enables
st_data_size_o  out  2  size
valid_o  out  1  completion pulse
trans_id_o  out  TRANS_ID_BITS  id of completed store
ex_valid_o  out  1  completion carries exception
ex_cause_o  out  64  6 = store misaligned, 15 = store page fault
ex_tval_o  out  64  faulting vaddr

Behaviour:
- Reset: state IDLE, all request/paddr registers 0, valid_o = ex_valid_o = 0, trans_id_o = ex_cause_o = ex_tval_o = 0.
- Combinational outputs are 0 whenever not driven by the state rules below.
- FSM states: IDLE, TRANSLATE, WAIT_STORE. ready_o = (state == IDLE).
- IDLE:
  - Accept when valid_i && !flush_i; capture vaddr, data, be, size, trans_id.
  - Misaligned if size 3 with vaddr[2:0] != 0, size 2 with vaddr[1:0] != 0, or size 1 with vaddr[0] != 0.
  - Misaligned: next cycle valid_o=1, ex_valid_o=1, cause 6, tval=vaddr; stay IDLE; no translation, no push.
  - Aligned: go to TRANSLATE.
- TRANSLATE:
  - translation_req_o=1, vaddr_o=captured vaddr.
  - No dtlb_hit_i: hold.
  - dtlb_hit_i && mmu_exception_i: next cycle completion with ex_valid_o=1, cause 15, tval=vaddr; go IDLE; no push.
  - dtlb_hit_i && !mmu_exception_i: st_valid_without_flush_o=1, st_paddr_o=paddr_i. Also latch paddr_i.
    - If st_ready_i: st_valid_o=1; completion (valid_o=1, ex_valid_o=0) next cycle; go IDLE.
    - Else: go WAIT_STORE.
- WAIT_STORE:
  - st_paddr_o = latched paddr, st_valid_without_flush_o=1, translation_req_o=0.
  - When st_ready_i: st_valid_o=1, completion next cycle, go IDLE.
- st_valid_o is always gated by !flush_i. st_data_o, st_be_o and st_data_size_o always show the captured values.
- Completion:
  - Registered single-cycle pulse; trans_id_o = captured id.
  - ex_cause_o and ex_tval_o are 0 for non-exception completions.
- Flush:
  - In any state, flush_i forces next state IDLE and suppresses any completion or push that would be generated that cycle.
  - A completion already registered (visible in the flush cycle) is still presented.
  - A valid_i in the flush cycle is not accepted.
- Latency:
  - Aligned store with TLB hit and buffer ready: accept cycle N, push N+1, valid_o N+2.
  - Misaligned store: valid_o N+1.
  - Throughput: one store per 2 cycles maximum.
- Reset asserted mid-operation returns to IDLE immediately with all outputs at reset values.

Test Plan:
- Aligned double store vaddr=0x1000, trans_id=2; dtlb_hit and st_ready in cycle 1 -> st_valid_o=1 with st_paddr_o=paddr_i in cycle 1; valid_o=1, trans_id_o=2, ex_valid_o=0 in cycle 2.
- Word store vaddr=0x1002 -> no translation_req_o; next cycle valid_o=1, ex_valid_o=1, ex_cause_o=6, ex_tval_o=0x1002.
- dtlb_hit_i delayed 3 cycles -> translation_req_o held high throughout; push occurs on the hit cycle.
- Hit with mmu_exception_i=1, vaddr=0x8000_0000 -> st_valid_o never asserted; completion with ex_cause_o=15, ex_tval_o=0x8000_0000.
- Hit with st_ready_i=0 for 4 cycles -> WAIT_STORE; st_valid_without_flush_o=1 and st_paddr_o stable; push on the first cycle st_ready_i=1.
- flush_i in WAIT_STORE -> st_valid_o=0, no valid_o follows, ready_o=1 next cycle.
